// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared widths, defaults and fetch state encoding
package instr_fetch_unit_pkg;
  localparam int INSTR_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_MAX_OUT = 2;
  typedef enum logic {RUN, DRAIN} fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: circular instruction queue with wrap-around pointers and occupancy count
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W = 2 * INSTR_W,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_pop;
  // clear wins over push/pop; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    do_pop = pop && count_q != '0;
    mem_d = mem_q;
    if (push && !clr) mem_d[wptr_q] = push_data;
    wptr_d = clr ? '0 : wptr_q + AW'(push);
    rptr_d = clr ? '0 : rptr_q + AW'(do_pop);
    count_d = clr ? '0 : count_q + CW'(push) - CW'(do_pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  // storage needs no reset: entries are only read while counted as occupied
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end
  assign head = mem_q[rptr_q];
  assign count = count_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-limited instruction fetcher with redirect drain and in-order address tags
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int DEPTH = DEF_DEPTH,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  output logic [31:0] ins_data,
  output logic [31:0] ins_pc,
  input  logic        ins_ready,
  output logic        err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(MAX_OUT - 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] MAXO_C = CW'(MAX_OUT);
  fetch_state_e state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outst_q, outst_d, count;
  logic err_q, err_d;
  logic [31:0] tag_q [MAX_OUT];
  logic [31:0] tag_d [MAX_OUT];
  logic [TW-1:0] twr_q, twr_d, trd_q, trd_d;
  logic accept, resp, push, pop;
  logic [2*INSTR_W-1:0] head;
  fetch_fifo #(.DEPTH(DEPTH), .W(2 * INSTR_W)) u_fifo (
    .CLK(CLK),
    .RESET(RESET),
    .clr(redirect),
    .push(push),
    .push_data({imem_rdata, tag_q[trd_q]}),
    .pop(pop),
    .head(head),
    .count(count)
  );
  // request credit, response classification and head-of-queue outputs
  always_comb begin
    imem_req = !RESET && !redirect && state_q == RUN && ({1'b0, count} + {1'b0, outst_q} < DEPTH_C) && outst_q < MAXO_C;
    imem_addr = fetch_pc_q & ~32'h3;
    accept = imem_req && imem_ready;
    resp = imem_rvalid && outst_q != '0;
    push = resp && state_q == RUN && !redirect;
    ins_valid = count != '0;
    ins_data = ins_valid ? head[2*INSTR_W-1:INSTR_W] : '0;
    ins_pc = ins_valid ? head[INSTR_W-1:0] : '0;
    pop = ins_valid && ins_ready;
    err = err_q;
  end
  // next fetch address, outstanding count, tag queue and RUN/DRAIN transitions
  always_comb begin
    outst_d = outst_q + CW'(accept) - CW'(resp);
    fetch_pc_d = redirect ? redirect_pc & ~32'h3 : accept ? fetch_pc_q + PC_INC : fetch_pc_q;
    state_d = (redirect || state_q == DRAIN) && outst_d != '0 ? DRAIN : RUN;
    err_d = err_q || (imem_rvalid && outst_q == '0);
    tag_d = tag_q;
    if (accept) tag_d[twr_q] = imem_addr;
    twr_d = accept ? (twr_q == TLAST ? '0 : twr_q + 1'b1) : twr_q;
    trd_d = resp ? (trd_q == TLAST ? '0 : trd_q + 1'b1) : trd_q;
  end
  // control state; reset discards everything in flight
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
      fetch_pc_q <= RESET_PC;
      outst_q <= '0;
      err_q <= 1'b0;
      twr_q <= '0;
      trd_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q <= outst_d;
      err_q <= err_d;
      twr_q <= twr_d;
      trd_q <= trd_d;
    end
  end
  // tag storage is qualified by the tag pointers, so it is left unreset
  always_ff @(posedge CLK) begin
    tag_q <= tag_d;
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: vector table, corner sequences and random run against a stream model
module tb_instr_fetch_unit;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam int MAXO = 2;
  typedef struct {
    logic rst, rdy, irdy, full, req;
    logic [31:0] addr;
    logic valid;
    logic [31:0] pc;
  } vec_t;
  logic CLK = 1'b0, RESET = 1'b1, imem_ready = 1'b0, imem_rvalid = 1'b0, redirect = 1'b0, ins_ready = 1'b0;
  logic [31:0] imem_rdata = '0, redirect_pc = '0;
  logic imem_req, ins_valid, err;
  logic [31:0] imem_addr, ins_data, ins_pc;
  int n_cmp = 0, n_fail = 0, t = 0, mem_lat = 1, last_due = 0;
  bit rand_lat = 0, mem_clr = 1, force_rv = 0;
  logic [31:0] mq_addr[$];
  int mq_due[$];
  logic s_req, s_valid, s_err, s_rvalid;
  logic [31:0] s_addr, s_pc, s_data;
  vec_t tbl[20];

  instr_fetch_unit dut (
    .CLK(CLK), .RESET(RESET), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc), .ins_ready(ins_ready), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk1(input string nm, input logic a, input logic e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0d)", nm, a, e, t);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d)", nm, a, e, t);
    end
  endtask

  // one clock cycle: drive inputs and memory response at negedge, sample after settling
  task automatic cyc(input logic rst, input logic rdy, input logic irdy, input logic rd, input logic [31:0] rpc);
    int lat, due;
    @(negedge CLK);
    RESET = rst; imem_ready = rdy; ins_ready = irdy; redirect = rd; redirect_pc = rpc;
    if (rst && mem_clr) begin
      mq_addr.delete(); mq_due.delete(); last_due = t;
    end
    if (force_rv) begin
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    end else if (mq_due.size() > 0 && mq_due[0] <= t) begin
      imem_rvalid = 1'b1; imem_rdata = mq_addr[0] ^ KEY;
      void'(mq_addr.pop_front()); void'(mq_due.pop_front());
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = ins_valid; s_pc = ins_pc;
    s_data = ins_data; s_err = err; s_rvalid = imem_rvalid;
    if (imem_req && rdy) begin
      lat = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
      due = t + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq_addr.push_back(imem_addr); mq_due.push_back(due);
    end
    t++;
  endtask

  task automatic do_reset();
    mem_clr = 1;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk1("rst_req", s_req, 0); chk1("rst_valid", s_valid, 0); chk1("rst_err", s_err, 0);
    chk32("rst_pc", s_pc, 0); chk32("rst_data", s_data, 0);
  endtask

  function automatic vec_t v(input logic rst, input logic rdy, input logic irdy, input logic full,
                             input logic req, input logic [31:0] addr, input logic valid, input logic [31:0] pc);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.irdy = irdy; r.full = full; r.req = req; r.addr = addr; r.valid = valid; r.pc = pc;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc, exp_ra, hp, hd;
    int mout, pops;
    bit hold;
    tbl[0]  = v(1, 1, 1, 0, 0, 0, 0, 0);
    tbl[1]  = v(1, 1, 1, 1, 0, 0, 0, 0);
    tbl[2]  = v(0, 1, 1, 1, 1, 32'd0, 0, 0);
    tbl[3]  = v(0, 1, 1, 1, 1, 32'd4, 0, 0);
    tbl[4]  = v(0, 1, 1, 1, 1, 32'd8, 1, 32'd0);
    tbl[5]  = v(0, 1, 1, 1, 1, 32'd12, 1, 32'd4);
    tbl[6]  = v(0, 1, 1, 1, 1, 32'd16, 1, 32'd8);
    tbl[7]  = v(0, 1, 1, 1, 1, 32'd20, 1, 32'd12);
    tbl[8]  = v(1, 1, 0, 0, 0, 0, 0, 0);
    tbl[9]  = v(1, 1, 0, 1, 0, 0, 0, 0);
    tbl[10] = v(0, 1, 0, 1, 1, 32'd0, 0, 0);
    tbl[11] = v(0, 1, 0, 1, 1, 32'd4, 0, 0);
    tbl[12] = v(0, 1, 0, 1, 1, 32'd8, 1, 32'd0);
    tbl[13] = v(0, 1, 0, 1, 1, 32'd12, 1, 32'd0);
    tbl[14] = v(0, 1, 0, 1, 0, 0, 1, 32'd0);
    tbl[15] = v(0, 1, 0, 1, 0, 0, 1, 32'd0);
    tbl[16] = v(0, 1, 1, 1, 0, 0, 1, 32'd0);
    tbl[17] = v(0, 1, 0, 1, 1, 32'd16, 1, 32'd4);
    tbl[18] = v(0, 1, 0, 1, 0, 0, 1, 32'd4);
    tbl[19] = v(0, 1, 0, 1, 0, 0, 1, 32'd4);
    mem_lat = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].rst, tbl[i].rdy, tbl[i].irdy, 0, 0);
      chk1($sformatf("vec%0d_req", i), s_req, tbl[i].req);
      if (tbl[i].full) begin
        if (tbl[i].req) chk32($sformatf("vec%0d_addr", i), s_addr, tbl[i].addr);
        chk1($sformatf("vec%0d_valid", i), s_valid, tbl[i].valid);
        chk32($sformatf("vec%0d_pc", i), s_pc, tbl[i].pc);
        chk32($sformatf("vec%0d_data", i), s_data, tbl[i].valid ? tbl[i].pc ^ KEY : 32'h0);
        chk1($sformatf("vec%0d_err", i), s_err, 0);
      end
    end

    // redirect with two requests in flight at latency 3
    mem_lat = 3;
    do_reset();
    cyc(0, 1, 1, 0, 0); chk1("r28_req0", s_req, 1); chk32("r28_addr0", s_addr, 32'h0);
    cyc(0, 1, 1, 0, 0); chk1("r28_req1", s_req, 1); chk32("r28_addr1", s_addr, 32'h4);
    cyc(0, 1, 1, 1, 32'h0000_1003); chk1("r28_redir_req", s_req, 0);
    cyc(0, 1, 1, 0, 0); chk1("r28_drain_req0", s_req, 0); chk1("r28_drain_valid0", s_valid, 0);
    cyc(0, 1, 1, 0, 0); chk1("r28_drain_req1", s_req, 0); chk1("r28_drain_valid1", s_valid, 0);
    cyc(0, 1, 1, 0, 0); chk1("r28_resume_req", s_req, 1); chk32("r28_resume_addr", s_addr, 32'h1000);
    for (int i = 0; i < 8 && !s_valid; i++) cyc(0, 1, 1, 0, 0);
    chk1("r28_first_valid", s_valid, 1); chk32("r28_first_pc", s_pc, 32'h1000);
    chk32("r28_first_data", s_data, 32'h1000 ^ KEY); chk1("r28_err", s_err, 0);

    // redirect coincident with a response and a pop
    mem_lat = 1;
    do_reset();
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 32'h0000_0200); chk1("r29_pop_valid", s_valid, 1); chk1("r29_redir_req", s_req, 0);
    cyc(0, 1, 1, 0, 0); chk1("r29_empty", s_valid, 0); chk1("r29_req", s_req, 1);
    chk32("r29_addr", s_addr, 32'h200); chk1("r29_err", s_err, 0);
    for (int i = 0; i < 8 && !s_valid; i++) cyc(0, 1, 1, 0, 0);
    chk1("r29_valid", s_valid, 1); chk32("r29_pc", s_pc, 32'h200); chk1("r29_err2", s_err, 0);

    // unsolicited response with a full queue
    do_reset();
    repeat (6) cyc(0, 1, 0, 0, 0);
    force_rv = 1;
    cyc(0, 1, 0, 0, 0);
    force_rv = 0;
    cyc(0, 1, 0, 0, 0); chk1("r30_err", s_err, 1); chk1("r30_valid", s_valid, 1); chk32("r30_pc", s_pc, 32'h0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 1, 0, 0);
      chk1($sformatf("r30_pop%0d_valid", k), s_valid, 1);
      chk32($sformatf("r30_pop%0d_pc", k), s_pc, 32'(4 * k));
      chk32($sformatf("r30_pop%0d_data", k), s_data, 32'(4 * k) ^ KEY);
    end
    repeat (3) cyc(0, 1, 1, 0, 0);
    chk1("r30_err_sticky", s_err, 1);

    // reset mid-stream with two outstanding
    mem_lat = 3;
    do_reset();
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    mem_clr = 0;
    cyc(1, 1, 1, 0, 0); chk1("r31_rst_req", s_req, 0);
    mem_clr = 1;
    cyc(0, 1, 1, 0, 0); chk1("r31_req", s_req, 1); chk32("r31_addr", s_addr, 32'h0); chk1("r31_valid", s_valid, 0);
    cyc(0, 1, 1, 0, 0); chk1("r31_late_err", s_err, 1);

    // random traffic against the instruction-stream model
    rand_lat = 1;
    do_reset();
    exp_pc = 0; exp_ra = 0; mout = 0; pops = 0; hold = 0; hp = 0; hd = 0;
    for (int i = 0; i < 2000; i++) begin
      logic rdy, irdy, rd;
      logic [31:0] rpc;
      rdy = $urandom_range(0, 9) < 7;
      irdy = $urandom_range(0, 9) < 6;
      rd = $urandom_range(0, 29) == 0;
      rpc = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 | ($urandom & 32'hF) : $urandom;
      cyc(0, rdy, irdy, rd, rpc);
      if (hold) begin
        chk1("rnd_hold_valid", s_valid, 1); chk32("rnd_hold_pc", s_pc, hp); chk32("rnd_hold_data", s_data, hd);
      end
      if (s_valid && irdy) begin
        chk32("rnd_pc", s_pc, exp_pc); chk32("rnd_data", s_data, exp_pc ^ KEY);
        exp_pc = exp_pc + 32'd4; pops++;
      end
      if (!s_valid) begin
        chk32("rnd_idle_pc", s_pc, 0); chk32("rnd_idle_data", s_data, 0);
      end
      if (rd) chk1("rnd_redir_req", s_req, 0);
      if (s_req) chk1("rnd_credit", mout < MAXO, 1);
      if (s_req && rdy) begin
        chk32("rnd_addr", s_addr, exp_ra); exp_ra = exp_ra + 32'd4; mout++;
      end
      if (s_rvalid) mout--;
      if (rd) begin
        exp_pc = rpc & ~32'h3; exp_ra = rpc & ~32'h3;
      end
      chk1("rnd_err", s_err, 0);
      hold = s_valid && !irdy && !rd; hp = s_pc; hd = s_data;
    end
    chk1("rnd_progress", pops > 100, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL run on one clock, CLK, with a synchronous, active-high reset, RESET.
REQ-002 Parameter RESET_PC, default 32'h0: first fetch address after reset.
REQ-003 Parameter DEPTH, default 4: instruction queue entries (power of 2, >=2).
REQ-004 Parameter MAX_OUT, default 2: maximum outstanding memory requests (1..DEPTH).
REQ-005 Ports:
- CLK  in  1  clock.
- RESET  in  1  sync active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  byte address of the word to fetch.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; responses return in order, at least 1 cycle after acceptance.
- imem_rdata  in  32  instruction word.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch address.
- ins_valid  out  1  head of queue valid.
- ins_data  out  32  instruction at head.
- ins_pc  out  32  address of the head instruction.
- ins_ready  in  1  instruction-register stage consumes the head.
- err  out  1  sticky protocol error.

Function
REQ-006 Request accepted when imem_req && imem_ready; fetch_pc advances by 4 (mod 2^32) on the following edge.
REQ-007 imem_addr SHALL equal fetch_pc with bits [1:0] forced to 0; redirect_pc[1:0] is ignored.
REQ-008 FSM states: RUN and DRAIN.
REQ-009 In RUN: imem_req = 1 iff (occupancy + outstanding) < DEPTH and outstanding < MAX_OUT.
REQ-010 In DRAIN: imem_req = 0. Responses are discarded and decrement outstanding. The FSM returns to RUN on the edge where outstanding becomes 0.
REQ-011 redirect (any state): queue is cleared and fetch_pc <= {redirect_pc[31:2],2'b00}. The FSM enters DRAIN if outstanding after this cycle is >0, otherwise RUN. imem_req SHALL be 0 in the redirect cycle.
REQ-012 A response coincident with redirect SHALL be discarded and counted against outstanding.
REQ-013 Each request SHALL record its address. In RUN, a response SHALL push {imem_rdata, recorded address} into the queue.
REQ-014 ins_valid = queue not empty. ins_data/ins_pc are the head entry, and 0 when empty.
REQ-015 Pop when ins_valid && ins_ready. Push and pop in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-016 Latency: response at edge N gives ins_valid at edge N+1. There is no combinational path from imem_rdata to ins_*.
REQ-017 A pop in the redirect cycle SHALL count as consumed. The queue is empty the next cycle regardless.
REQ-018 The credit rule (REQ-009) SHALL make overflow impossible. imem_rvalid with outstanding = 0 SHALL set err and be ignored.
REQ-019 Outputs SHALL hold stable while ins_valid && !ins_ready.

Reset
REQ-020 On RESET high at an edge, the block SHALL set:
- fetch_pc = RESET_PC
- state = RUN
- occupancy = 0, outstanding = 0
- err = 0, ins_valid = 0, ins_data = 0, ins_pc = 0
- imem_req = 0 while RESET is high.
REQ-021 Responses arriving after a reset SHALL be treated as unsolicited (REQ-018). Reset mid-operation SHALL discard all in-flight state.
REQ-022 The first cycle with RESET low SHALL assert imem_req with imem_addr = RESET_PC.

Structure
REQ-023 A shared package SHALL hold INSTR_W=32, PC_INC=4, the defaults for DEPTH/MAX_OUT, and the fetch state enum {RUN, DRAIN}.
REQ-024 Queue storage and pointers SHALL be a sub-module, fetch_fifo: circular buffer, wrap-around pointers, occupancy counter.
REQ-025 Requested addresses SHALL be held in a MAX_OUT-deep in-order tag queue inside instr_fetch_unit.

Verification
REQ-026 Reset, then imem_ready=1 and 1-cycle-latency memory returning addr^32'hA5A5_0000, ins_ready=1 -> ins_pc sequence 0,4,8,12 with matching ins_data, one per cycle at steady state.
REQ-027 ins_ready=0, memory always ready -> exactly DEPTH=4 requests (addrs 0..12), ins_valid held with ins_pc=0. Then ins_ready=1 for one cycle -> exactly one new request at addr 16.
REQ-028 Two requests outstanding (addrs 0,4, latency 3), redirect with redirect_pc=32'h0000_1003 -> both responses dropped, imem_req low until drained, next request addr 32'h1000, first ins_pc = 32'h1000.
REQ-029 redirect coincident with imem_rvalid and with ins_ready && ins_valid -> queue empty the next cycle, err stays 0, fetch resumes at redirect_pc.
REQ-030 imem_rvalid pulsed with nothing outstanding -> err=1 and stays high until RESET; queue unchanged.
REQ-031 RESET asserted mid-stream with 2 outstanding -> the cycle after release, imem_addr=RESET_PC and ins_valid=0; late responses set err.
